// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the multicycle RV32I core.
// Owns the PC and fetches one word per request into the instruction register.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic        pc_write,
   input  logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        ir_write,
   output logic [31:0] instr_data,
   output logic [31:0] pc,
   output logic [31:0] pc_old,
   output logic        fetch_done,
   output logic        busy,
   output logic        fetch_fault,
   output logic [1:0]  fault_code
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] counter;
   logic          accept;
   logic          aligned;
   logic          to_hit;

   // DONE behaves like IDLE for acceptance, enabling back-to-back fetches
   assign accept  = fetch_start && (state == IDLE || state == DONE);
   assign aligned = (pc[1:0] == 2'b00);
   assign to_hit  = (TIMEOUT_CYCLES != 0) && (counter == TMAX);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (fetch_start) begin
               state_next = aligned ? BUSY : FAULT;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_next = DONE;
            end else if (to_hit) begin
               state_next = FAULT;
            end
         end
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs straight from state so reset drops them at once
   always_comb begin
      mem_req     = (state == BUSY);
      ir_write    = (state == DONE);
      fetch_done  = (state == DONE);
      fetch_fault = (state == FAULT);
      busy        = (state != IDLE);
   end

   // Datapath: PC, latched address, fetched word, fault cause, wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= RESET_PC;
         pc_old     <= RESET_PC;
         mem_addr   <= RESET_PC;
         instr_data <= 32'h0;
         fault_code <= 2'b00;
         counter    <= '0;
      end else begin
         if (accept) begin
            if (aligned) begin
               mem_addr   <= pc;
               counter    <= '0;
               fault_code <= 2'b00;
            end else begin
               fault_code <= 2'b01;
            end
         end
         if (state == BUSY) begin
            if (mem_ready) begin
               instr_data <= mem_rdata;
               pc_old     <= mem_addr;
               pc         <= mem_addr + 32'd4;
            end else if (to_hit) begin
               fault_code <= 2'b10;
            end else begin
               counter <= counter + 1'b1;
            end
         end
         if (pc_write) begin
            pc <= pc_next;
         end
      end
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the multicycle RV32I core; sits directly upstream of the instruction register.
- Owns the PC and runs a valid/ready read handshake to instruction memory.
- Registers the returned word and pulses ir_write so the instruction register captures instr_data.
- Detects misaligned fetch addresses and memory timeouts, and reports them to the control FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles mem_req may stay high without mem_ready; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- fetch_start  input  1  control FSM request to fetch at the current pc.
- pc_write  input  1  load pc from pc_next (branch/jump).
- pc_next  input  32  new PC value.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  32  fetch address; stable while mem_req=1.
- mem_ready  input  1  read data valid this cycle; sampled only while mem_req=1.
- mem_rdata  input  32  read data.
- ir_write  output  1  one-cycle pulse; instr_data valid; drives instruction register enable.
- instr_data  output  32  fetched instruction; drives instruction register data in.
- pc  output  32  current PC.
- pc_old  output  32  address of the most recently fetched instruction.
- fetch_done  output  1  one-cycle pulse, same cycle as ir_write.
- busy  output  1  1 when state is not IDLE.
- fetch_fault  output  1  one-cycle fault pulse.
- fault_code  output  2  cause of the last fault: 01 misaligned, 10 timeout, 00 none; held until the next accepted fetch_start.

Behaviour:
- Reset (asynchronous on reset=0, overrides everything):
  - state=IDLE; pc=pc_old=mem_addr=RESET_PC; instr_data=0; fault_code=0.
  - mem_req, ir_write, fetch_done, fetch_fault all 0; timeout counter=0.
  - Reset mid-request drops mem_req immediately, with no ir_write.
- State IDLE:
  - fetch_start=1 with pc[1:0]==0 -> BUSY; mem_addr<=pc; counter<=0; fault_code<=0.
  - fetch_start=1 with pc[1:0]!=0 -> FAULT; fault_code<=01; no memory request is issued.
- State BUSY:
  - mem_req=1 and mem_addr is held.
  - mem_ready=1 -> DONE; instr_data<=mem_rdata; pc_old<=mem_addr; pc<=mem_addr+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - mem_ready=0 and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> FAULT; fault_code<=10; pc unchanged. Otherwise counter increments.
  - mem_req is therefore high for at most TIMEOUT_CYCLES cycles.
- State DONE:
  - ir_write=1 and fetch_done=1 for exactly one cycle.
  - Next state is IDLE. If fetch_start=1 in DONE, the IDLE acceptance rules apply to the updated pc (back-to-back fetch).
- State FAULT:
  - fetch_fault=1 for one cycle, then IDLE.
  - No ir_write; instr_data and pc_old are unchanged.
- pc_write:
  - Accepted in any state; pc<=pc_next.
  - When coincident with the BUSY->DONE increment, pc_write wins.
  - pc_write during BUSY does not change mem_addr; the in-flight fetch completes at the latched address.
- fetch_start while BUSY or FAULT is ignored (not queued).
- Minimum latency is 2 cycles from fetch_start to ir_write (zero-wait memory). Each wait cycle adds 1.
- ir_write and fetch_fault are never high together.

Test Plan:
- Reset release, fetch_start at pc=0, mem_ready=1 on the first mem_req cycle, mem_rdata=32'h00500093:
  - mem_addr=0.
  - ir_write and fetch_done high 2 cycles after fetch_start, with instr_data=32'h00500093.
  - pc=4 and pc_old=0.
- pc=32'h100, mem_ready delayed 3 cycles:
  - mem_req high exactly 4 cycles with mem_addr=32'h100 stable.
  - ir_write 5 cycles after fetch_start; pc=32'h104.
- TIMEOUT_CYCLES=4, mem_ready held at 0:
  - mem_req high exactly 4 cycles, then a one-cycle fetch_fault with fault_code=10.
  - No ir_write; pc unchanged.
- pc_write with pc_next=32'h2 then fetch_start:
  - No mem_req; fetch_fault pulse with fault_code=01.
  - A subsequent pc_write to 32'h8 plus fetch_start clears fault_code to 00 and fetches from 32'h8.
- pc_write with pc_next=32'h200 in the same cycle as mem_ready for a fetch at 32'h40:
  - pc=32'h200 and pc_old=32'h40.
  - The next fetch_start issues mem_addr=32'h200.
- Wrap-around and reset:
  - Fetch at 32'hFFFF_FFFC yields pc=0.
  - Asserting reset=0 mid-BUSY drops mem_req in the same cycle, restores pc=RESET_PC, and produces no ir_write.
